// File: rtl/udma_jtag_fifo_setup_tx.sv
// Channel-setup initiator: queues setup commands and sends each packed word across a
// 4-phase valid/ack handshake. Optional watchdog: define SETUP_TX_TIMEOUT_EN.
module udma_jtag_fifo_setup_tx #(
    parameter int CFG_WIDTH   = 57,
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_txrxn_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [21:0]          cmd_size_i,
    input  logic [1:0]           cmd_dsize_i,
    output logic [CFG_WIDTH-1:0] setup_value_o,
    output logic                 setup_valid_o,
    input  logic                 setup_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 57;

    if (CFG_WIDTH < PW || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_params
        $error("udma_jtag_fifo_setup_tx: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_e;

    logic [PW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 fifo_full, fifo_empty, push, pop;
    logic                 ack_meta_q, ack_s_q;
    state_e               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [CFG_WIDTH-1:0] value_q, value_d;
    logic                 done_q, done_d;
    logic                 req_tmo, rel_tmo;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push        = cmd_valid_i & ~fifo_full;
    assign cmd_ready_o = ~fifo_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    // Queue storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_dsize_i, cmd_txrxn_i, cmd_addr_i, cmd_size_i};
        end
    end

`ifdef SETUP_TX_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_flag_q, err_flag_d;
    logic        err_q, err_d;

    // Timeout fires on the edge where the counter would reach TIMEOUT_CYC-1.
    assign req_tmo = (state_q == S_REQ) && ((cnt_q + 16'd1) == TMO_LAST);
    assign rel_tmo = (state_q == S_REL) && ((cnt_q + 16'd1) == TMO_LAST);
    assign err_o   = err_q;
`else
    assign req_tmo = 1'b0;
    assign rel_tmo = 1'b0;
    assign err_o   = 1'b0;
`endif

    // State register and all control flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            done_q     <= 1'b0;
`ifdef SETUP_TX_TIMEOUT_EN
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ack_meta_q <= setup_ack_i;
            ack_s_q    <= ack_meta_q;
            valid_q    <= valid_d;
            value_q    <= value_d;
            done_q     <= done_d;
`ifdef SETUP_TX_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic; a stale-high ack at REQ entry is accepted as the ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_REQ;
            S_REQ:  if (ack_s_q || req_tmo) state_d = S_REL;
            S_REL:  if (!ack_s_q || rel_tmo) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, computed one cycle ahead so every handshake output is registered.
    always_comb begin
        pop     = (state_q == S_REL) && (state_d == S_IDLE);
        valid_d = (state_d == S_REQ);
        value_d = value_q;
        if (state_q == S_IDLE && state_d == S_REQ) begin
            value_d         = '0;
            value_d[PW-1:0] = mem_q[rd_ptr_q[AW-1:0]];
        end
`ifdef SETUP_TX_TIMEOUT_EN
        cnt_d      = '0;
        if (state_d != S_IDLE && state_d == state_q) cnt_d = cnt_q + 16'd1;
        err_flag_d = err_flag_q;
        if (state_q == S_IDLE && state_d == S_REQ) err_flag_d = 1'b0;
        if (state_q == S_REQ && state_d == S_REL && !ack_s_q) err_flag_d = 1'b1;
        done_d     = pop & ~err_flag_q;
        err_d      = pop & err_flag_q;
`else
        done_d     = pop;
`endif
    end

    assign setup_valid_o = valid_q;
    assign setup_value_o = value_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_udma_jtag_fifo_setup_tx.sv
// Directed bench for udma_jtag_fifo_setup_tx; the watchdog section runs only when
// SETUP_TX_TIMEOUT_EN is defined.
module tb_udma_jtag_fifo_setup_tx;
`ifdef SETUP_TX_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_txrxn_i;
    logic [31:0] cmd_addr_i;
    logic [21:0] cmd_size_i;
    logic [1:0]  cmd_dsize_i;
    logic [56:0] setup_value_o;
    logic        setup_valid_o, setup_ack_i, busy_o, done_o, err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int snap;

    udma_jtag_fifo_setup_tx #(.CFG_WIDTH(57), .FIFO_DEPTH(2), .TIMEOUT_CYC(TB_TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_txrxn_i(cmd_txrxn_i),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_dsize_i(cmd_dsize_i),
        .setup_value_o(setup_value_o), .setup_valid_o(setup_valid_o), .setup_ack_i(setup_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (err_o)  err_cnt  <= err_cnt + 1;
    end

    function automatic logic [56:0] pack(input logic [1:0] ds, input logic tx,
                                         input logic [31:0] a, input logic [21:0] s);
        return {ds, tx, a, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic set_cmd(input logic [1:0] ds, input logic tx,
                           input logic [31:0] a, input logic [21:0] s);
        cmd_dsize_i = ds; cmd_txrxn_i = tx; cmd_addr_i = a; cmd_size_i = s;
        cmd_valid_i = 1'b1;
    endtask

    task automatic wait_valid(input logic lvl);
        for (int i = 0; i < 40 && setup_valid_o !== lvl; i++) tick(1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_o !== 1'b1; i++) tick(1);
    endtask

    // Waits for a request, checks its word, and completes the 4-phase exchange.
    task automatic handshake(input string tag, input logic [56:0] exp);
        wait_valid(1'b1);
        chk({tag, "_req"}, 64'(setup_valid_o), 64'd1);
        chk({tag, "_value"}, 64'(setup_value_o), 64'(exp));
        setup_ack_i = 1'b1;
        wait_valid(1'b0);
        chk({tag, "_valid_drop"}, 64'(setup_valid_o), 64'd0);
        setup_ack_i = 1'b0;
        wait_done();
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        tick(1);
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; setup_ack_i = 1'b0;
        cmd_txrxn_i = 1'b0; cmd_addr_i = '0; cmd_size_i = '0; cmd_dsize_i = '0;
        tick(3);
        chk("rst_valid", 64'(setup_valid_o), 64'd0);
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_done",  64'(done_o), 64'd0);
        chk("rst_err",   64'(err_o), 64'd0);
        chk("rst_value", 64'(setup_value_o), 64'd0);
        rst_i = 1'b0;
        tick(2);

        // Single TX command, ack raised 3 cycles after valid
        set_cmd(2'd2, 1'b1, 32'h1C00_0100, 22'h40);
        tick(1);
        cmd_valid_i = 1'b0;
        chk("t1_valid_e0", 64'(setup_valid_o), 64'd0);
        chk("t1_busy_e0",  64'(busy_o), 64'd1);
        tick(1);
        chk("t1_valid_e1", 64'(setup_valid_o), 64'd1);
        chk("t1_value",    64'(setup_value_o), 64'h0147_0000_4000_0040);
        tick(2);
        setup_ack_i = 1'b1;
        tick(2);
        chk("t1_valid_hold", 64'(setup_valid_o), 64'd1);
        tick(1);
        chk("t1_valid_low", 64'(setup_valid_o), 64'd0);
        setup_ack_i = 1'b0;
        tick(2);
        chk("t1_no_done_yet", 64'(done_o), 64'd0);
        tick(1);
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_idle", 64'(busy_o), 64'd0);
        tick(1);
        chk("t1_done_pulse", 64'(done_o), 64'd0);
        chk("t1_value_kept", 64'(setup_value_o), 64'h0147_0000_4000_0040);
        chk("t1_done_count", 64'(done_cnt), 64'd1);

        // Three back-to-back commands into a 2-deep queue while ack is stalled
        tick(2);
        snap = done_cnt;
        set_cmd(2'd0, 1'b0, 32'h0000_0004, 22'h3F_FFFF);
        tick(1);
        chk("t2_ready_1", 64'(cmd_ready_o), 64'd1);
        set_cmd(2'd3, 1'b1, 32'hFFFF_FFFF, 22'h0);
        tick(1);
        chk("t2_full", 64'(cmd_ready_o), 64'd0);
        set_cmd(2'd1, 1'b0, 32'h8000_0000, 22'h1);
        tick(3);
        chk("t2_still_full", 64'(cmd_ready_o), 64'd0);
        chk("t2_a_valid", 64'(setup_valid_o), 64'd1);
        chk("t2_a_value", 64'(setup_value_o),
            64'(pack(2'd0, 1'b0, 32'h0000_0004, 22'h3F_FFFF)));
        setup_ack_i = 1'b1;
        wait_valid(1'b0);
        chk("t2_a_drop", 64'(setup_valid_o), 64'd0);
        setup_ack_i = 1'b0;
        wait_done();
        chk("t2_a_done", 64'(done_o), 64'd1);
        chk("t2_ready_after_done", 64'(cmd_ready_o), 64'd1);
        tick(1);
        cmd_valid_i = 1'b0;
        chk("t2_b_next", 64'(setup_valid_o), 64'd1);
        handshake("t2_b", pack(2'd3, 1'b1, 32'hFFFF_FFFF, 22'h0));
        handshake("t2_c", pack(2'd1, 1'b0, 32'h8000_0000, 22'h1));
        tick(2);
        chk("t2_drained", 64'(busy_o), 64'd0);
        chk("t2_done_count", 64'(done_cnt - snap), 64'd3);

        // Reset pulsed in the middle of a request with a full queue
        snap = done_cnt;
        set_cmd(2'd1, 1'b1, 32'h0000_1000, 22'h10);
        tick(1);
        set_cmd(2'd1, 1'b1, 32'h0000_2000, 22'h20);
        tick(1);
        cmd_valid_i = 1'b0;
        chk("t3_in_req", 64'(setup_valid_o), 64'd1);
        chk("t3_full",   64'(cmd_ready_o), 64'd0);
        #3 rst_i = 1'b1;
        #1;
        chk("t3_valid_async", 64'(setup_valid_o), 64'd0);
        chk("t3_busy",  64'(busy_o), 64'd0);
        chk("t3_ready", 64'(cmd_ready_o), 64'd1);
        tick(1);
        rst_i = 1'b0;
        tick(5);
        chk("t3_stay_idle", 64'(setup_valid_o), 64'd0);
        chk("t3_no_done", 64'(done_cnt - snap), 64'd0);

        // Ack toggled while idle is ignored, then a normal transfer
        snap = done_cnt;
        setup_ack_i = 1'b1;
        tick(4);
        chk("t4_no_req",  64'(setup_valid_o), 64'd0);
        chk("t4_no_busy", 64'(busy_o), 64'd0);
        chk("t4_ready",   64'(cmd_ready_o), 64'd1);
        setup_ack_i = 1'b0;
        tick(4);
        chk("t4_no_done", 64'(done_cnt - snap), 64'd0);
        set_cmd(2'd2, 1'b0, 32'h1234_5678, 22'h2A_BCDE);
        tick(1);
        cmd_valid_i = 1'b0;
        handshake("t4_d", pack(2'd2, 1'b0, 32'h1234_5678, 22'h2A_BCDE));
        chk("t4_done_count", 64'(done_cnt - snap), 64'd1);
        chk("t4_err", 64'(err_cnt), 64'd0);

`ifdef SETUP_TX_TIMEOUT_EN
        // Watchdog: ack never returns, request abandoned after 15 cycles
        tick(2);
        snap = done_cnt;
        set_cmd(2'd0, 1'b1, 32'hA000_0000, 22'h8);
        tick(1);
        cmd_valid_i = 1'b0;
        tick(1);
        chk("t5_req", 64'(setup_valid_o), 64'd1);
        tick(14);
        chk("t5_hold_14", 64'(setup_valid_o), 64'd1);
        tick(1);
        chk("t5_drop_15", 64'(setup_valid_o), 64'd0);
        tick(1);
        chk("t5_err_pulse", 64'(err_o), 64'd1);
        chk("t5_no_done", 64'(done_o), 64'd0);
        tick(3);
        chk("t5_err_count", 64'(err_cnt), 64'd1);
        chk("t5_done_count", 64'(done_cnt - snap), 64'd0);
        chk("t5_popped", 64'(busy_o), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
